// File: rtl/clk_div_sequencer.sv
// clk_div_sequencer: programmable clock-enable divider; new divisors apply only on period boundaries
// Optional period_cnt output enabled by CLKDIV_PERIOD_CNT_EN.
module clk_div_sequencer #(
  parameter int DIV_W     = 28,
  parameter int RESET_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_en,
  output logic             div_out,
  output logic             tick,
  output logic             running,
`ifdef CLKDIV_PERIOD_CNT_EN
  output logic [15:0]      period_cnt,
`endif
  output logic [DIV_W-1:0] cur_div
);
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO = DIV_W'(2);
  localparam logic [DIV_W-1:0] RST_DIV = (RESET_DIV < 2) ? TWO : DIV_W'(RESET_DIV);
  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
  state_t state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n, cur_div_n, pend_div, pend_div_n, div_c;
  logic pend_en, pend_en_n, accept, wrap;
  always_comb begin
    div_c = (cfg_div < TWO) ? TWO : cfg_div;
    cfg_ready = state != PEND;
    running = state != IDLE;
    accept = cfg_valid && cfg_ready;
    wrap = cnt >= cur_div - ONE;
    state_n = state;
    cnt_n = running ? (wrap ? '0 : cnt + ONE) : '0;
    cur_div_n = cur_div;
    pend_div_n = pend_div;
    pend_en_n = pend_en;
    case (state)
      IDLE: if (accept) begin
        cur_div_n = div_c;
        state_n = cfg_en ? RUN : IDLE;
      end
      RUN: if (accept) begin
        pend_div_n = div_c;
        pend_en_n = cfg_en;
        state_n = PEND;
      end
      PEND: if (wrap) begin
        cur_div_n = pend_div;
        state_n = pend_en ? RUN : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cur_div <= RST_DIV;
      pend_div <= '0;
      pend_en <= 1'b0;
      div_out <= 1'b0;
      tick <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cur_div <= cur_div_n;
      pend_div <= pend_div_n;
      pend_en <= pend_en_n;
      div_out <= running && (cnt < (cur_div >> 1));
      tick <= running && wrap;
    end
  end
`ifdef CLKDIV_PERIOD_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || accept) period_cnt <= '0;
    else if (tick) period_cnt <= period_cnt + 16'd1;
  end
`endif
endmodule
